uart_rx_frame: RTL and testbench

UART receiver: recovers asynchronous serial frames from the line input using 16x oversampling and presents each received character as a parallel byte with a one-cycle valid strobe and error flags. It is the receive-side counterpart of the existing UART transmit path in `control`. It uses the same run-time selects for parity, baud rate and data length. Its outputs feed the display/LED path.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_rx_frame_baud_tick.sv | 35 +++
 rtl/uart_rx_frame.sv | 172 +++++++++++++++++
 tb/tb_uart_rx_frame.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART receive definitions: FSM state encoding, default baud
// divisors and 16x oversampling constants.
package uart_pkg;

    // Receiver FSM states; PARITY is only reachable when UART_RX_PARITY_EN is defined.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_WAIT   = 3'd5
    } rx_state_e;

    // Clocks per oversample tick at 50 MHz: 115200 baud and 9600 baud.
    localparam int DIV_FAST_DEF = 27;
    localparam int DIV_SLOW_DEF = 326;

    // 16 ticks per bit; sample at os==7 (8th tick), bit ends at os==15.
    localparam int         OS_RATE = 16;
    localparam logic [3:0] OS_MID  = 4'd7;
    localparam logic [3:0] OS_LAST = 4'd15;

    // Number of data bits for a given data-length select.
    function automatic logic [3:0] data_bits(input logic dls);
        return dls ? 4'd8 : 4'd7;
    endfunction

endpackage

// File: rtl/uart_rx_frame_baud_tick.sv
// Oversample tick generator shared with the transmit path. Counts clk up to
// the selected divisor and emits a one-cycle tick; held at 0 while en is low
// so the first tick of a frame always lands a full divisor after enable.
module uart_baud_tick #(
    parameter int DIV_FAST = uart_pkg::DIV_FAST_DEF,
    parameter int DIV_SLOW = uart_pkg::DIV_SLOW_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic sel,
    output logic tick
);

    localparam int DIV_MAX = (DIV_SLOW > DIV_FAST) ? DIV_SLOW : DIV_FAST;
    localparam int CW      = (DIV_MAX < 2) ? 1 : $clog2(DIV_MAX);

    logic [CW-1:0] cnt;
    logic [CW-1:0] lim;

    assign lim  = sel ? CW'(DIV_FAST - 1) : CW'(DIV_SLOW - 1);
    assign tick = en && (cnt == lim);

    // Divisor counter: cleared when disabled or on wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (!en || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/uart_rx_frame.sv
// UART receiver with 16x oversampling. Recovers start / 7 or 8 data bits /
// optional even parity / stop, and presents the character on data with a
// one-cycle valid strobe plus parity and framing error flags.
// Optional feature macro: UART_RX_PARITY_EN (parity bit and perr support;
// without it paritys is ignored and perr is tied low).
// Handshake: valid is a one-cycle strobe with no ready; data/perr/ferr hold
// their values until the next valid.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int DIV_FAST = DIV_FAST_DEF,
    parameter int DIV_SLOW = DIV_SLOW_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxi,
    input  logic       paritys,
    input  logic       bauds,
    input  logic       dls,
    output logic [7:0] data,
    output logic       valid,
    output logic       perr,
    output logic       ferr,
    output logic       busy,
    output logic [2:0] dbg_state
);

    rx_state_e  state, state_n;
    logic       rx_meta, rxs;
    logic       tick, mid, bit_end, start_det, data_smp, stop_smp;
    logic [3:0] os;
    logic [3:0] bitn;
    logic [7:0] shreg;
    logic       baud_q, dls_q;
`ifdef UART_RX_PARITY_EN
    logic       par_q, par_acc, par_smp;
`else
    logic       unused_paritys;
    assign unused_paritys = paritys;
`endif

    // Two-flop synchronizer on the serial line; idles high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rxi;
            rxs     <= rx_meta;
        end
    end

    uart_baud_tick #(
        .DIV_FAST (DIV_FAST),
        .DIV_SLOW (DIV_SLOW)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .en    (state != ST_IDLE),
        .sel   (baud_q),
        .tick  (tick)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_n;
    end

    // FSM next-state logic.
    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:  if (!rxs) state_n = ST_START;
            ST_START: begin
                if (mid && rxs)   state_n = ST_IDLE;   // false start
                else if (bit_end) state_n = ST_DATA;
            end
            ST_DATA: begin
                if (bit_end && (bitn == data_bits(dls_q))) begin
`ifdef UART_RX_PARITY_EN
                    state_n = par_q ? ST_PARITY : ST_STOP;
`else
                    state_n = ST_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: if (bit_end) state_n = ST_STOP;
`endif
            ST_STOP:  if (mid) state_n = rxs ? ST_IDLE : ST_WAIT;
            ST_WAIT:  if (rxs) state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    // FSM outputs: sample strobes, busy and debug state.
    always_comb begin
        mid       = tick && (os == OS_MID);
        bit_end   = tick && (os == OS_LAST);
        start_det = (state == ST_IDLE) && !rxs;
        data_smp  = (state == ST_DATA) && mid;
        stop_smp  = (state == ST_STOP) && mid;
`ifdef UART_RX_PARITY_EN
        par_smp   = (state == ST_PARITY) && mid;
`endif
        busy      = (state != ST_IDLE) || valid;
        dbg_state = state;
    end

    // Oversample position, bit index, shift register and per-frame config latch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            os      <= '0;
            bitn    <= '0;
            shreg   <= '0;
            baud_q  <= 1'b0;
            dls_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
            par_acc <= 1'b0;
`endif
        end else begin
            if (state == ST_IDLE) begin
                os <= '0;
                if (start_det) begin
                    bitn   <= '0;
                    baud_q <= bauds;
                    dls_q  <= dls;
`ifdef UART_RX_PARITY_EN
                    par_q   <= paritys;
                    par_acc <= 1'b0;
`endif
                end
            end else if (tick) begin
                os <= os + 4'd1;
            end
            if (data_smp) begin
                shreg <= {rxs, shreg[7:1]};
                bitn  <= bitn + 4'd1;
`ifdef UART_RX_PARITY_EN
                par_acc <= par_acc ^ rxs;
`endif
            end
`ifdef UART_RX_PARITY_EN
            if (par_smp) par_acc <= par_acc ^ rxs;
`endif
        end
    end

    // Result registers: loaded at the stop sample, valid one clock later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data  <= '0;
            valid <= 1'b0;
            perr  <= 1'b0;
            ferr  <= 1'b0;
        end else begin
            valid <= stop_smp;
            if (stop_smp) begin
                data <= dls_q ? shreg : {1'b0, shreg[7:1]};
                ferr <= !rxs;
`ifdef UART_RX_PARITY_EN
                perr <= par_q & par_acc;
`else
                perr <= 1'b0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame. Fast rate uses the real 27-clock divisor;
// the slow divisor is shortened to 40 clocks to keep the run short.
module tb_uart_rx_frame;

    localparam int FAST = 27;
    localparam int SLOW = 40;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rxi = 1'b1;
    logic       paritys = 1'b0;
    logic       bauds = 1'b1;
    logic       dls = 1'b1;
    logic [7:0] data;
    logic       valid, perr, ferr, busy;
    logic [2:0] dbg_state;

    int checks = 0;
    int errors = 0;

    uart_rx_frame #(
        .DIV_FAST (FAST),
        .DIV_SLOW (SLOW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rxi       (rxi),
        .paritys   (paritys),
        .bauds     (bauds),
        .dls       (dls),
        .data      (data),
        .valid     (valid),
        .perr      (perr),
        .ferr      (ferr),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Watchdog
    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Valid monitor: counts strobes, captures outputs, measures pulse width
    int         n_valid = 0;
    int         v_run = 0;
    int         v_len = 0;
    int         t_valid = 0;
    int         t_edge = 0;
    logic [7:0] v_data = 8'h00;
    logic       v_perr = 1'b0;
    logic       v_ferr = 1'b0;

    always @(negedge clk) begin
        if (valid) begin
            if (v_run == 0) begin
                n_valid = n_valid + 1;
                t_valid = cyc;
                v_data  = data;
                v_perr  = perr;
                v_ferr  = ferr;
            end
            v_run = v_run + 1;
        end else if (v_run != 0) begin
            v_len = v_run;
            v_run = 0;
        end
    end

    // Driver tasks
    task automatic hold_bit(input logic b, input int div);
        rxi = b;
        repeat (16 * div) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input int nbits, input bit par,
                              input logic pbit, input logic stopb, input int div);
        @(negedge clk);
        t_edge = cyc;
        hold_bit(1'b0, div);
        for (int i = 0; i < nbits; i++) hold_bit(b[i], div);
        if (par) hold_bit(pbit, div);
        hold_bit(stopb, div);
        rxi = 1'b1;
    endtask

    task automatic test_reset();
        repeat (5) @(negedge clk);
        checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", data); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
        checks++; if (perr !== 1'b0) begin errors++; $display("FAIL reset_perr got %b want 0", perr); end
        checks++; if (ferr !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b want 0", ferr); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        reset = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_fast_8n1();
        int nv0;
        nv0 = n_valid;
        bauds = 1'b1; dls = 1'b1; paritys = 1'b0;
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, FAST);
        repeat (4) @(negedge clk);
        checks++; if (n_valid !== nv0 + 1) begin errors++; $display("FAIL a5_count got %0d want %0d", n_valid - nv0, 1); end
        checks++; if (v_data !== 8'hA5) begin errors++; $display("FAIL a5_data got %h want a5", v_data); end
        checks++; if (v_len !== 1) begin errors++; $display("FAIL a5_valid_width got %0d want 1", v_len); end
        checks++; if (v_perr !== 1'b0) begin errors++; $display("FAIL a5_perr got %b want 0", v_perr); end
        checks++; if (v_ferr !== 1'b0) begin errors++; $display("FAIL a5_ferr got %b want 0", v_ferr); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL a5_busy_after got %b want 0", busy); end
        // 3 clocks to start detect + 152 ticks of 27 clocks
        checks++; if (t_valid - t_edge !== 4107) begin errors++; $display("FAIL a5_latency got %0d want 4107", t_valid - t_edge); end
    endtask

    task automatic test_parity();
        int   nv0;
        int   exp_lat;
        logic exp_perr;
`ifdef UART_RX_PARITY_EN
        exp_perr = 1'b1;
        exp_lat  = 3 + 168 * FAST;
`else
        exp_perr = 1'b0;
        exp_lat  = 3 + 152 * FAST;
`endif
        nv0 = n_valid;
        bauds = 1'b1; dls = 1'b1; paritys = 1'b1;
        send_frame(8'h3C, 8, 1'b1, 1'b1, 1'b1, FAST);
        repeat (4) @(negedge clk);
        paritys = 1'b0;
        checks++; if (n_valid !== nv0 + 1) begin errors++; $display("FAIL par_count got %0d want 1", n_valid - nv0); end
        checks++; if (v_data !== 8'h3C) begin errors++; $display("FAIL par_data got %h want 3c", v_data); end
        checks++; if (v_perr !== exp_perr) begin errors++; $display("FAIL par_perr got %b want %b", v_perr, exp_perr); end
        checks++; if (v_ferr !== 1'b0) begin errors++; $display("FAIL par_ferr got %b want 0", v_ferr); end
        checks++; if (perr !== exp_perr) begin errors++; $display("FAIL par_perr_held got %b want %b", perr, exp_perr); end
        checks++; if (t_valid - t_edge !== exp_lat) begin errors++; $display("FAIL par_latency got %0d want %0d", t_valid - t_edge, exp_lat); end
    endtask

    task automatic test_slow_7n1();
        int nv0;
        nv0 = n_valid;
        bauds = 1'b0; dls = 1'b0;
        fork
            send_frame(8'h55, 7, 1'b0, 1'b0, 1'b1, SLOW);
            begin
                // selects changed mid-frame must not affect this frame
                repeat (1000) @(negedge clk);
                bauds = 1'b1; dls = 1'b1;
            end
        join
        repeat (4) @(negedge clk);
        checks++; if (n_valid !== nv0 + 1) begin errors++; $display("FAIL s7_count got %0d want 1", n_valid - nv0); end
        checks++; if (v_data !== 8'h55) begin errors++; $display("FAIL s7_data got %h want 55", v_data); end
        checks++; if (v_ferr !== 1'b0) begin errors++; $display("FAIL s7_ferr got %b want 0", v_ferr); end
        // 3 clocks + 136 ticks of 40 clocks
        checks++; if (t_valid - t_edge !== 5443) begin errors++; $display("FAIL s7_latency got %0d want 5443", t_valid - t_edge); end
    endtask

    task automatic test_glitch();
        int nv0;
        nv0 = n_valid;
        @(negedge clk);
        rxi = 1'b0;
        repeat (3 * FAST) @(negedge clk);
        rxi = 1'b1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_during got %b want 1", busy); end
        repeat (250) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_after got %b want 0", busy); end
        checks++; if (n_valid !== nv0) begin errors++; $display("FAIL glitch_no_valid got %0d want 0", n_valid - nv0); end
    endtask

    task automatic test_break();
        int nv0;
        int waited;
        nv0 = n_valid;
        @(negedge clk);
        rxi = 1'b0;
        repeat (20 * 16 * FAST) @(negedge clk);
        checks++; if (n_valid !== nv0 + 1) begin errors++; $display("FAIL brk_count got %0d want 1", n_valid - nv0); end
        checks++; if (v_data !== 8'h00) begin errors++; $display("FAIL brk_data got %h want 00", v_data); end
        checks++; if (v_ferr !== 1'b1) begin errors++; $display("FAIL brk_ferr got %b want 1", v_ferr); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL brk_busy_low_line got %b want 1", busy); end
        rxi = 1'b1;
        waited = 0;
        while (busy === 1'b1 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL brk_busy_release got %b want 0", busy); end
        repeat (16 * FAST) @(negedge clk);
        send_frame(8'h81, 8, 1'b0, 1'b0, 1'b1, FAST);
        repeat (4) @(negedge clk);
        checks++; if (n_valid !== nv0 + 2) begin errors++; $display("FAIL brk_next_count got %0d want 2", n_valid - nv0); end
        checks++; if (v_data !== 8'h81) begin errors++; $display("FAIL brk_next_data got %h want 81", v_data); end
        checks++; if (v_ferr !== 1'b0) begin errors++; $display("FAIL brk_next_ferr got %b want 0", v_ferr); end
    endtask

    task automatic test_reset_mid();
        int         nv0;
        logic [7:0] b;
        nv0 = n_valid;
        b = 8'h12;
        @(negedge clk);
        hold_bit(1'b0, FAST);
        for (int i = 0; i < 4; i++) hold_bit(b[i], FAST);
        rxi = b[4];
        repeat (8 * FAST) @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (data !== 8'h00) begin errors++; $display("FAIL rst_mid_data got %h want 00", data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b want 0", busy); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got %b want 0", valid); end
        checks++; if (ferr !== 1'b0 || perr !== 1'b0) begin errors++; $display("FAIL rst_mid_errs got %b%b want 00", ferr, perr); end
        @(negedge clk);
        rxi = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (16 * FAST) @(negedge clk);
        send_frame(8'h12, 8, 1'b0, 1'b0, 1'b1, FAST);
        repeat (4) @(negedge clk);
        checks++; if (n_valid !== nv0 + 1) begin errors++; $display("FAIL rst_next_count got %0d want 1", n_valid - nv0); end
        checks++; if (v_data !== 8'h12) begin errors++; $display("FAIL rst_next_data got %h want 12", v_data); end
    endtask

    task automatic test_back_to_back();
        int nv0;
        nv0 = n_valid;
        send_frame(8'h3A, 8, 1'b0, 1'b0, 1'b1, FAST);
        checks++; if (v_data !== 8'h3A) begin errors++; $display("FAIL b2b_first_data got %h want 3a", v_data); end
        send_frame(8'hC5, 8, 1'b0, 1'b0, 1'b1, FAST);
        repeat (4) @(negedge clk);
        checks++; if (n_valid !== nv0 + 2) begin errors++; $display("FAIL b2b_count got %0d want 2", n_valid - nv0); end
        checks++; if (v_data !== 8'hC5) begin errors++; $display("FAIL b2b_second_data got %h want c5", v_data); end
        checks++; if (v_ferr !== 1'b0) begin errors++; $display("FAIL b2b_ferr got %b want 0", v_ferr); end
    endtask

    // Test sequence and final report
    initial begin
        test_reset();
        test_fast_8n1();
        test_parity();
        test_slow_7n1();
        test_glitch();
        test_break();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
